// File: rtl/conv_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : conv_frame_loader
//  Description : Ping-pong frame assembler for the convolution input stage.
//                Collects paired A/B samples into N-sample frames held in two
//                banks and presents each closed frame in parallel, zero-padded
//                past its length, while the other bank keeps filling.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_frame_loader #(
   parameter int N  = 21,
   parameter int W  = 21,
   parameter int LW = $clog2(N + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   input  logic            in_last,
   output logic            frame_valid,
   input  logic            frame_ready,
   output logic [N*W-1:0]  frame_a,
   output logic [N*W-1:0]  frame_b,
   output logic [LW-1:0]   frame_len,
   output logic            frame_short
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FILLING = 2'd1,
      S_FULL    = 2'd2
   } bank_state_t;

   localparam logic [LW-1:0] c_last_idx = LW'(N - 1);
   localparam logic [LW-1:0] c_n        = LW'(N);

   // Per-bank storage; sample payload is never reset, only the bookkeeping.
   logic [W-1:0]   r_mem_a [2][N];
   logic [W-1:0]   r_mem_b [2][N];
   bank_state_t    r_state [2];
   logic [LW-1:0]  r_len   [2];
   logic           r_short [2];

   logic           r_wr_bank;
   logic           r_rd_bank;
   logic [LW-1:0]  r_wr_idx;

   logic           w_accept;
   logic           w_close;
   logic           w_take;
   logic [LW-1:0]  w_idx_inc;
   logic [LW-1:0]  w_rd_len;

   // Readiness and presentation are decoded purely from registered bank state.
   assign in_ready    = (r_state[r_wr_bank] != S_FULL);
   assign frame_valid = (r_state[r_rd_bank] == S_FULL);

   assign w_accept  = in_valid && in_ready;
   assign w_idx_inc = r_wr_idx + LW'(1);
   assign w_close   = w_accept && ((r_wr_idx == c_last_idx) || in_last);
   assign w_take    = frame_valid && frame_ready;

   assign w_rd_len    = r_len[r_rd_bank];
   assign frame_len   = frame_valid ? w_rd_len : '0;
   assign frame_short = frame_valid && r_short[r_rd_bank];

   // Entries at or beyond the frame length read as zero so stale data from an
   // earlier, longer frame in the same bank never leaks to the consumer.
   for (genvar k = 0; k < N; k++) begin : g_pad
      localparam logic [LW-1:0] c_k = LW'(k);
      assign frame_a[k*W +: W] = (c_k < w_rd_len) ? r_mem_a[r_rd_bank][k] : '0;
      assign frame_b[k*W +: W] = (c_k < w_rd_len) ? r_mem_b[r_rd_bank][k] : '0;
   end

   // Sample write port: store each accepted pair at the current fill index.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_a[r_wr_bank][r_wr_idx] <= in_a;
         r_mem_b[r_wr_bank][r_wr_idx] <= in_b;
      end
   end

   // Bank bookkeeping: fill/close on the input side, release on the output side.
   // A close and a release never target the same bank, since a bank being
   // filled is not FULL and a bank being presented is.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state[0] <= S_EMPTY;
         r_state[1] <= S_EMPTY;
         r_len[0]   <= '0;
         r_len[1]   <= '0;
         r_short[0] <= 1'b0;
         r_short[1] <= 1'b0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_wr_idx   <= '0;
      end else begin
         if (w_accept) begin
            if (w_close) begin
               r_state[r_wr_bank] <= S_FULL;
               r_len[r_wr_bank]   <= w_idx_inc;
               r_short[r_wr_bank] <= (w_idx_inc < c_n);
               r_wr_idx           <= '0;
               r_wr_bank          <= ~r_wr_bank;
            end else begin
               r_state[r_wr_bank] <= S_FILLING;
               r_wr_idx           <= w_idx_inc;
            end
         end
         if (w_take) begin
            r_state[r_rd_bank] <= S_EMPTY;
            r_rd_bank          <= ~r_rd_bank;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_frame_loader
//  Description : Self-checking bench for conv_frame_loader. A queue of closed
//                frames models the two banks; outputs are compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_frame_loader;

   localparam int N  = 21;
   localparam int W  = 21;
   localparam int LW = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic            in_last;
   logic            frame_valid;
   logic            frame_ready;
   logic [N*W-1:0]  frame_a;
   logic [N*W-1:0]  frame_b;
   logic [LW-1:0]   frame_len;
   logic            frame_short;

   conv_frame_loader #(.N(N), .W(W), .LW(LW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_last     (in_last),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_a     (frame_a),
      .frame_b     (frame_b),
      .frame_len   (frame_len),
      .frame_short (frame_short)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*W-1:0] a;
      logic [N*W-1:0] b;
      int             len;
      logic           sh;
   } frame_t;

   // Reference: closed frames waiting for the consumer, plus the open frame.
   frame_t          q[$];
   logic [N*W-1:0]  cur_a;
   logic [N*W-1:0]  cur_b;
   int              cur_n;

   int n_chk = 0;
   int n_err = 0;
   int ready_low_cnt = 0;

   task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_s();
      return W'($urandom_range(32'h1FFFFE, 0));
   endfunction

   task automatic model_clear();
      q.delete();
      cur_a = '0;
      cur_b = '0;
      cur_n = 0;
   endtask

   task automatic check_outputs();
      logic           ev;
      logic [LW-1:0]  el;
      logic           es;
      ev = (q.size() > 0);
      el = ev ? LW'(q[0].len) : '0;
      es = ev ? q[0].sh : 1'b0;
      chk("in_ready", in_ready, (q.size() < 2));
      chk("frame_valid", frame_valid, ev);
      chk("frame_len", frame_len, el);
      chk("frame_short", frame_short, es);
      if (ev && frame_valid) begin
         chk("frame_a", frame_a, q[0].a);
         chk("frame_b", frame_b, q[0].b);
      end
   endtask

   // One clock: drive at negedge, compare, then advance the model at posedge.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic last, input logic fr);
      logic   acc;
      logic   tk;
      frame_t f;
      @(negedge clk);
      in_valid    = v;
      in_a        = a;
      in_b        = b;
      in_last     = last;
      frame_ready = fr;
      check_outputs();
      if (!in_ready) ready_low_cnt++;
      @(posedge clk);
      acc = v && (q.size() < 2);
      tk  = fr && (q.size() > 0);
      if (tk) void'(q.pop_front());
      if (acc) begin
         cur_a[cur_n*W +: W] = a;
         cur_b[cur_n*W +: W] = b;
         cur_n++;
         if (last || cur_n == N) begin
            f.a   = cur_a;
            f.b   = cur_b;
            f.len = cur_n;
            f.sh  = (cur_n < N);
            q.push_back(f);
            cur_a = '0;
            cur_b = '0;
            cur_n = 0;
         end
      end
   endtask

   task automatic idle(input int n, input logic fr);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, fr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      frame_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_last = 1'b0;
      frame_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      do_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_frame_len", frame_len, 0);
      chk("rst_frame_short", frame_short, 0);

      // Full frame of known ramp values.
      for (int k = 0; k < N; k++) step(1'b1, W'(k + 1), W'(2*k + 1), 1'b0, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      chk("t1_a20", frame_a[20*W +: W], 21);
      chk("t1_b0", frame_b[0 +: W], 1);
      chk("t1_len", frame_len, 21);
      chk("t1_short", frame_short, 0);
      idle(3, 1'b1);

      // Random full frame, then a short frame into a bank holding stale data.
      for (int k = 0; k < N; k++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
      idle(3, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b1, rnd_s(), rnd_s(), (k == 4), 1'b0);
      idle(1, 1'b0);
      @(negedge clk);
      chk("t2_len", frame_len, 5);
      chk("t2_short", frame_short, 1);
      chk("t2_pad_a", frame_a[N*W-1:5*W], 0);
      chk("t2_pad_b", frame_b[N*W-1:5*W], 0);
      idle(3, 1'b1);

      // Both banks fill with the consumer stalled; blocked pushes are ignored.
      for (int k = 0; k < 2*N; k++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 21'h1FFFFF, 21'h1FFFFF, 1'b0, 1'b0);
      step(1'b1, 21'h1FFFFF, 21'h1FFFFF, 1'b0, 1'b1);
      idle(3, 1'b0);
      idle(3, 1'b1);

      // Back-to-back frames with a one-cycle consumer pulse every N cycles.
      ready_low_cnt = 0;
      for (int i = 0; i < 5*N; i++)
         step(1'b1, rnd_s(), rnd_s(), 1'b0, (i > 0) && (i % N == 0));
      chk("t4_no_stall", ready_low_cnt, 0);
      idle(4, 1'b1);

      // Reset with a full frame and a partial frame in flight.
      for (int k = 0; k < N + 10; k++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
      do_reset();
      chk("t5_valid", frame_valid, 0);
      chk("t5_ready", in_ready, 1);
      for (int k = 0; k < N; k++) step(1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0);
      idle(1, 1'b0);
      @(negedge clk);
      chk("t5_len", frame_len, 21);
      idle(3, 1'b1);

      // Random traffic: mixed lengths, bursty producer and consumer.
      for (int i = 0; i < 400; i++)
         step($urandom_range(3, 0) != 0, rnd_s(), rnd_s(),
              $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1);
      idle(6, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
